// File: rtl/ex_redirect_ctrl_pkg.sv
// Shared pipeline definitions: redirect controller state encoding and
// the default flush/wait depths used by the EX redirect controller.
package PipelineReg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_FLUSH    = 2'd2,
    ST_WAIT     = 2'd3
  } ExCtrlState_t;

  localparam int unsigned DEFAULT_FLUSH_DEPTH = 2;
  localparam int unsigned DEFAULT_WAIT_LIMIT  = 15;

endpackage

// File: rtl/ex_redirect_ctrl_load_use_detect.sv
// Combinational load-use hazard compare: a load in EX whose destination
// (other than x0) feeds either source operand of the instruction in ID.
module load_use_detect (
  input  logic       i_ex_valid,
  input  logic       i_ex_memread,
  input  logic [4:0] i_ex_rd,
  input  logic [4:0] i_id_rs1,
  input  logic [4:0] i_id_rs2,
  output logic       o_hazard
);

  logic w_rd_nonzero;
  logic w_src_match;

  assign w_rd_nonzero = (i_ex_rd != 5'd0);
  assign w_src_match  = (i_ex_rd == i_id_rs1) || (i_ex_rd == i_id_rs2);
  assign o_hazard     = i_ex_valid && i_ex_memread && w_rd_nonzero && w_src_match;

endmodule

// File: rtl/ex_redirect_ctrl.sv
// EX-stage redirect controller: on a taken branch/jump it steers fetch to
// the registered target, squashes IF/ID for the bubble window, then squashes
// ID/EX until the instruction entering EX carries the target NPC (bounded).
// In IDLE it also stalls on load-use hazards; a redirect wins over a stall.
// Optional event counters are built when EX_CTRL_STATS_EN is defined.
module ex_redirect_ctrl
  import PipelineReg::*;
#(
  parameter int unsigned FLUSH_DEPTH = DEFAULT_FLUSH_DEPTH,
  parameter int unsigned WAIT_LIMIT  = DEFAULT_WAIT_LIMIT
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_ex_valid,
  input  logic        i_ex_branch,
  input  logic        i_ex_jump,
  input  logic        i_branch_taken,
  input  logic [31:0] i_target_pc,
  input  logic [31:0] i_ex_npc,
  input  logic        i_ex_memread,
  input  logic [4:0]  i_ex_rd,
  input  logic [4:0]  i_id_rs1,
  input  logic [4:0]  i_id_rs2,
  output logic        o_pc_sel,
  output logic [31:0] o_pc_target,
  output logic        o_flush_ifid,
  output logic        o_flush_idex,
  output logic        o_stall_if,
  output logic        o_stall_id,
  output logic        o_busy,
  output logic [31:0] o_redirect_cnt,
  output logic [31:0] o_stall_cnt
);

  localparam logic [2:0] LP_FLUSH_LOAD = 3'(FLUSH_DEPTH - 1);
  localparam logic [7:0] LP_WAIT_LAST  = 8'(WAIT_LIMIT - 1);

  ExCtrlState_t r_state, w_state_next;
  logic [2:0]   r_flush_cnt, w_flush_cnt_next;
  logic [7:0]   r_wait_cnt, w_wait_cnt_next;
  logic [31:0]  r_pc_target, w_pc_target_next;
  logic         w_redirect_ev;
  logic         w_load_use;
  logic         w_take;
  logic         w_stall;
  logic         w_pc_sel, w_flush_ifid, w_flush_idex;

  assign w_redirect_ev = i_ex_valid && (i_ex_jump || (i_ex_branch && i_branch_taken));

  load_use_detect u_load_use_detect (
    .i_ex_valid  (i_ex_valid),
    .i_ex_memread(i_ex_memread),
    .i_ex_rd     (i_ex_rd),
    .i_id_rs1    (i_id_rs1),
    .i_id_rs2    (i_id_rs2),
    .o_hazard    (w_load_use)
  );

  // Next-state, counter and control-output decode.
  always_comb begin
    w_state_next     = r_state;
    w_flush_cnt_next = r_flush_cnt;
    w_wait_cnt_next  = r_wait_cnt;
    w_pc_target_next = r_pc_target;
    w_take           = 1'b0;
    w_stall          = 1'b0;
    w_pc_sel         = 1'b0;
    w_flush_ifid     = 1'b0;
    w_flush_idex     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_redirect_ev) begin
          w_take           = 1'b1;
          w_pc_target_next = i_target_pc;
          w_state_next     = ST_REDIRECT;
        end else if (w_load_use) begin
          w_stall      = 1'b1;
          w_flush_idex = 1'b1;
        end
      end
      ST_REDIRECT: begin
        w_pc_sel         = 1'b1;
        w_flush_ifid     = 1'b1;
        w_flush_idex     = 1'b1;
        w_flush_cnt_next = LP_FLUSH_LOAD;
        w_state_next     = ST_FLUSH;
      end
      ST_FLUSH: begin
        w_flush_ifid = 1'b1;
        // Leave once the decrement reaches zero (a zero load leaves at once).
        if (r_flush_cnt <= 3'd1) begin
          w_flush_cnt_next = 3'd0;
          w_wait_cnt_next  = 8'd0;
          w_state_next     = ST_WAIT;
        end else begin
          w_flush_cnt_next = r_flush_cnt - 3'd1;
        end
      end
      ST_WAIT: begin
        if (i_ex_npc == r_pc_target) begin
          w_wait_cnt_next = 8'd0;
          w_state_next    = ST_IDLE;
        end else begin
          w_flush_idex = 1'b1;
          if (r_wait_cnt == LP_WAIT_LAST) begin
            w_wait_cnt_next = 8'd0;
            w_state_next    = ST_IDLE;
          end else begin
            w_wait_cnt_next = r_wait_cnt + 8'd1;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Control outputs are silenced while reset is held.
  always_comb begin
    o_pc_sel     = w_pc_sel && !i_reset;
    o_flush_ifid = w_flush_ifid && !i_reset;
    o_flush_idex = w_flush_idex && !i_reset;
    o_stall_if   = w_stall && !i_reset;
    o_stall_id   = w_stall && !i_reset;
  end

  assign o_pc_target = r_pc_target;
  assign o_busy      = (r_state != ST_IDLE);

  // State, target and bubble/wait counter registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_flush_cnt <= 3'd0;
      r_wait_cnt  <= 8'd0;
      r_pc_target <= 32'd0;
    end else begin
      r_state     <= w_state_next;
      r_flush_cnt <= w_flush_cnt_next;
      r_wait_cnt  <= w_wait_cnt_next;
      r_pc_target <= w_pc_target_next;
    end
  end

`ifdef EX_CTRL_STATS_EN
  logic [31:0] r_redirect_cnt, r_stall_cnt;

  // Wrapping event counters for accepted redirects and load-use stall cycles.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_redirect_cnt <= 32'd0;
      r_stall_cnt    <= 32'd0;
    end else begin
      if (w_take)  r_redirect_cnt <= r_redirect_cnt + 32'd1;
      if (w_stall) r_stall_cnt    <= r_stall_cnt + 32'd1;
    end
  end

  assign o_redirect_cnt = r_redirect_cnt;
  assign o_stall_cnt    = r_stall_cnt;
`else
  assign o_redirect_cnt = 32'd0;
  assign o_stall_cnt    = 32'd0;
`endif

endmodule

// File: tb/tb_ex_redirect_ctrl.sv
// Scoreboard bench for ex_redirect_ctrl: directed scenarios followed by
// random traffic, each cycle's expected outputs computed by a behavioural
// model and queued; a negedge monitor pops and compares.
module tb_ex_redirect_ctrl;

  localparam int FD = 2;
  localparam int WL = 15;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_ex_valid = 1'b0, i_ex_branch = 1'b0, i_ex_jump = 1'b0, i_branch_taken = 1'b0;
  logic [31:0] i_target_pc = '0, i_ex_npc = '0;
  logic        i_ex_memread = 1'b0;
  logic [4:0]  i_ex_rd = '0, i_id_rs1 = '0, i_id_rs2 = '0;
  logic        o_pc_sel, o_flush_ifid, o_flush_idex, o_stall_if, o_stall_id, o_busy;
  logic [31:0] o_pc_target, o_redirect_cnt, o_stall_cnt;

  always #5 clk = ~clk;

  ex_redirect_ctrl #(.FLUSH_DEPTH(FD), .WAIT_LIMIT(WL)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_ex_valid(i_ex_valid), .i_ex_branch(i_ex_branch),
    .i_ex_jump(i_ex_jump), .i_branch_taken(i_branch_taken), .i_target_pc(i_target_pc),
    .i_ex_npc(i_ex_npc), .i_ex_memread(i_ex_memread), .i_ex_rd(i_ex_rd),
    .i_id_rs1(i_id_rs1), .i_id_rs2(i_id_rs2), .o_pc_sel(o_pc_sel), .o_pc_target(o_pc_target),
    .o_flush_ifid(o_flush_ifid), .o_flush_idex(o_flush_idex), .o_stall_if(o_stall_if),
    .o_stall_id(o_stall_id), .o_busy(o_busy), .o_redirect_cnt(o_redirect_cnt),
    .o_stall_cnt(o_stall_cnt)
  );

  typedef struct packed {
    logic        pc_sel;
    logic [31:0] tgt;
    logic        fl_ifid;
    logic        fl_idex;
    logic        st_if;
    logic        st_id;
    logic        busy;
    logic [31:0] rc;
    logic [31:0] sc;
  } obs_t;

  typedef struct packed {
    bit   chk;
    obs_t o;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Behavioural model: where the controller is in the redirect sequence.
  // phase 0 = quiet, 1 = steering fetch, 2 = bubble window, 3 = waiting for target.
  int          m_phase = 0;
  int          m_bubbles_left = 0;
  int          m_waited = 0;
  logic [31:0] m_target = '0;
  logic [31:0] m_rc = '0, m_sc = '0;

  task automatic step(input logic rst, input logic v, input logic br, input logic jp,
                      input logic tk, input logic [31:0] tgt, input logic [31:0] npc,
                      input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input bit chk);
    exp_t e;
    bit   ev, lu;
    @(posedge clk);
    #1;
    i_reset = rst; i_ex_valid = v; i_ex_branch = br; i_ex_jump = jp; i_branch_taken = tk;
    i_target_pc = tgt; i_ex_npc = npc; i_ex_memread = mr; i_ex_rd = rd;
    i_id_rs1 = rs1; i_id_rs2 = rs2;
    ev = v && (jp || (br && tk));
    lu = v && mr && (rd != 0) && ((rd == rs1) || (rd == rs2));
    e = '0;
    e.chk    = chk;
    e.o.tgt  = m_target;
    e.o.busy = (m_phase != 0);
`ifdef EX_CTRL_STATS_EN
    e.o.rc = m_rc;
    e.o.sc = m_sc;
`endif
    if (!rst) begin
      if (m_phase == 0 && !ev && lu) begin
        e.o.st_if = 1'b1; e.o.st_id = 1'b1; e.o.fl_idex = 1'b1;
      end
      if (m_phase == 1) begin
        e.o.pc_sel = 1'b1; e.o.fl_ifid = 1'b1; e.o.fl_idex = 1'b1;
      end
      if (m_phase == 2) e.o.fl_ifid = 1'b1;
      if (m_phase == 3) e.o.fl_idex = (npc != m_target);
    end
    q.push_back(e);
    // Advance the model for the coming edge.
    if (rst) begin
      m_phase = 0; m_target = '0; m_rc = '0; m_sc = '0; m_bubbles_left = 0; m_waited = 0;
    end else begin
      case (m_phase)
        0: begin
          if (ev) begin
            m_target = tgt; m_phase = 1; m_rc = m_rc + 1;
            $display("txn redirect target=%08h t=%0t", tgt, $time);
          end else if (lu) begin
            m_sc = m_sc + 1;
            $display("txn load-use stall rd=%0d t=%0t", rd, $time);
          end
        end
        1: begin
          m_phase = 2;
          m_bubbles_left = (FD > 1) ? FD - 1 : 1;
        end
        2: begin
          m_bubbles_left = m_bubbles_left - 1;
          if (m_bubbles_left == 0) begin m_phase = 3; m_waited = 0; end
        end
        default: begin
          m_waited = m_waited + 1;
          if (npc == m_target || m_waited == WL) m_phase = 0;
        end
      endcase
    end
  endtask

  task automatic idle(input logic [31:0] npc);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, npc, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
  endtask

  // Monitor: compare DUT outputs against each queued expectation.
  initial begin
    exp_t e;
    obs_t a;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        a = '{o_pc_sel, o_pc_target, o_flush_ifid, o_flush_idex, o_stall_if, o_stall_id,
              o_busy, o_redirect_cnt, o_stall_cnt};
        if (e.chk) begin
          checks++;
          if (a !== e.o) begin
            errors++;
            $display("FAIL outputs t=%0t got sel=%b tgt=%08h fi=%b fx=%b si=%b sd=%b busy=%b rc=%0d sc=%0d required sel=%b tgt=%08h fi=%b fx=%b si=%b sd=%b busy=%b rc=%0d sc=%0d",
                     $time, a.pc_sel, a.tgt, a.fl_ifid, a.fl_idex, a.st_if, a.st_id, a.busy, a.rc, a.sc,
                     e.o.pc_sel, e.o.tgt, e.o.fl_ifid, e.o.fl_idex, e.o.st_if, e.o.st_id, e.o.busy, e.o.rc, e.o.sc);
          end
        end
      end
    end
  end

  initial begin
    logic        rst, v, br, jp, tk, mr;
    logic [31:0] tgt, npc;
    logic [4:0]  rd, rs1, rs2;
    int          budget;
    // Reset; the first cycle precedes any reset edge and is not compared.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
    idle(32'h0);
    // BEQ taken to 0x40, then target arrives in WAIT.
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h40, 32'h10, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
    idle(32'h14);
    idle(32'h18);
    idle(32'h40);
    idle(32'h44);
    // Branch not taken.
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h80, 32'h48, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
    idle(32'h4c);
    // LW x5 / ADD x6,x5,x1, then same with rd=x0.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h50, 1'b1, 5'd5, 5'd5, 5'd1, 1'b1);
    idle(32'h54);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h58, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1);
    // JAL together with a load-use match: redirect only.
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h100, 32'h5c, 1'b1, 5'd7, 5'd3, 5'd7, 1'b1);
    // Redirect events during the sequence are ignored.
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h200, 32'h60, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
    idle(32'h64);
    idle(32'h100);
    idle(32'h104);
    // Target never arrives: forced exit after WL wait cycles.
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h300, 32'h108, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
    for (int i = 0; i < WL + 6; i++) idle(32'hdead_0000);
    // Reset during the bubble window.
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h400, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
    idle(32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
    idle(32'h0);
    // Three redirects after reset.
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h500 + 32'(k * 16), 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
      idle(32'h0);
      idle(32'h0);
      idle(32'h500 + 32'(k * 16));
    end
    idle(32'h0);
    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      v   = ($urandom_range(0, 3) != 0);
      br  = $urandom_range(0, 1);
      jp  = ($urandom_range(0, 9) == 0);
      tk  = ($urandom_range(0, 3) == 0);
      mr  = ($urandom_range(0, 2) == 0);
      rd  = 5'($urandom_range(0, 3));
      rs1 = 5'($urandom_range(0, 3));
      rs2 = 5'($urandom_range(0, 3));
      tgt = {$urandom_range(0, 255), 2'b00};
      npc = ($urandom_range(0, 3) == 0) ? m_target : {$urandom_range(0, 255), 2'b00};
      step(rst, v, br, jp, tk, tgt, npc, mr, rd, rs1, rs2, 1'b1);
    end
    idle(32'h0);
    budget = 0;
    while (q.size() > 0 && budget < 10) begin
      @(posedge clk);
      budget++;
    end
    @(posedge clk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain got %0d pending required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_redirect_ctrl.md
EX_REDIRECT_CTRL -- requirements
Module: ex_redirect_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_DEPTH, default 2, meaning the number of bubble cycles inserted into IF/ID after a redirect (legal 1..7).
REQ-002 SHALL have parameter WAIT_LIMIT, default 15, meaning the maximum number of WAIT cycles before a forced return to IDLE (legal 1..255).
REQ-003 SHALL have i_clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have i_reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have i_ex_valid  in  1  EX stage holds a real instruction.
REQ-006 SHALL have i_ex_branch  in  1  EX instruction is a conditional branch.
REQ-007 SHALL have i_ex_jump  in  1  EX instruction is JAL/JALR.
REQ-008 SHALL have i_branch_taken  in  1  ALU branch-compare result.
REQ-009 SHALL have i_target_pc  in  32  redirect target computed by the ALU.
REQ-010 SHALL have i_ex_npc  in  32  NPC of the instruction now entering EX.
REQ-011 SHALL have i_ex_memread  in  1  EX instruction is a load.
REQ-012 SHALL have i_ex_rd, i_id_rs1, i_id_rs2  in  5 each  destination in EX; sources in ID.
REQ-013 SHALL have o_pc_sel  out  1  fetch takes o_pc_target instead of PC+4.
REQ-014 SHALL have o_pc_target  out  32  registered redirect target.
REQ-015 SHALL have o_flush_ifid, o_flush_idex  out  1 each  squash the named pipeline register.
REQ-016 SHALL have o_stall_if, o_stall_id  out  1 each  hold PC and IF/ID.
REQ-017 SHALL have o_busy  out  1  controller is not in IDLE.
REQ-018 SHALL have o_redirect_cnt, o_stall_cnt  out  32 each  event counters (see Configuration).

Function
REQ-019 SHALL implement states IDLE, REDIRECT, FLUSH, WAIT, all registered.
REQ-020 IDLE: redirect event = i_ex_valid & (i_ex_jump | (i_ex_branch & i_branch_taken)); on the event SHALL latch i_target_pc into o_pc_target and go to REDIRECT next cycle.
REQ-021 REDIRECT (exactly 1 cycle): o_pc_sel=1, o_flush_ifid=1, o_flush_idex=1; then to FLUSH with the bubble counter loaded to FLUSH_DEPTH-1.
REQ-022 FLUSH: o_flush_ifid=1 each cycle; decrement the counter; at 0 go to WAIT.
REQ-023 WAIT: o_flush_idex=1 while i_ex_npc != o_pc_target; when equal go to IDLE the same edge with no flush in that cycle; after WAIT_LIMIT cycles go to IDLE regardless.
REQ-024 Load-use hazard (IDLE only) = i_ex_valid & i_ex_memread & i_ex_rd!=0 & (i_ex_rd==i_id_rs1 | i_ex_rd==i_id_rs2); SHALL assert o_stall_if, o_stall_id, o_flush_idex combinationally for that cycle.
REQ-025 A simultaneous redirect event and load-use SHALL resolve to the redirect: no stall asserted.
REQ-026 Redirect events arriving outside IDLE SHALL be ignored; the EX slot is being squashed.
REQ-027 o_busy SHALL equal (state != IDLE); all other outputs not named in the current state SHALL be 0.

Reset
REQ-028 i_reset=1 at any edge SHALL force IDLE, o_pc_target=0, bubble/wait counters=0, all control outputs 0, counters 0; this overrides any in-flight redirect.

Configuration
REQ-029 Macro EX_CTRL_STATS_EN defined: o_redirect_cnt increments on each IDLE->REDIRECT transition and o_stall_cnt on each load-use stall cycle, both wrapping at 2^32; undefined: no counter flops, both outputs tied 0.

Structure
REQ-030 The state enum ExCtrlState_t and the defaults FLUSH_DEPTH/WAIT_LIMIT SHALL live in the shared PipelineReg package.
REQ-031 The load-use compare SHALL be a combinational sub-module load_use_detect instantiated once.

Verification
REQ-032 BEQ taken, target 0x0000_0040 -> next cycle o_pc_sel=1, o_pc_target=0x40, both flushes 1; then 1 FLUSH cycle; then IDLE once i_ex_npc=0x40.
REQ-033 Branch not taken (i_branch_taken=0) -> no output asserted, o_busy stays 0.
REQ-034 LW x5 in EX, ADD x6,x5,x1 in ID -> single-cycle stall_if/stall_id/flush_idex; with rd=x0 -> no stall.
REQ-035 JAL plus load-use in the same cycle -> redirect only, o_stall_if=0.
REQ-036 i_ex_npc never matches the target -> IDLE after exactly WAIT_LIMIT=15 WAIT cycles.
REQ-037 i_reset asserted during FLUSH -> all outputs 0 and IDLE on the next edge; with EX_CTRL_STATS_EN defined, 3 redirects -> o_redirect_cnt=3.
